// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with a circular return-address stack.
// Handles sequential fetch, absolute/relative branch, call/ret and stall,
// with sticky overflow/underflow flags that only a reset clears.
module pc_ras #(
    parameter int AW         = 8,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       rel,
    input  logic [AW-1:0]              target,
    output logic [AW-1:0]              pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] RST_PC   = AW'(RESET_ADDR);
    localparam logic [DW-1:0] DEPTH_DW = DW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [AW-1:0] stack [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] wptr_inc;
    logic [PW-1:0] wptr_dec;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] eff_target;
    logic [AW-1:0] top_entry;
    logic          push_en;

    // Next-address arithmetic and circular stack pointer neighbours; the write
    // pointer always names the slot the next push lands in, which is also the
    // oldest entry once the stack is full, so overflow overwrites it for free.
    always_comb begin
        pc_inc     = pc + AW'(1);
        eff_target = rel ? (pc + target) : target;
        wptr_inc   = (wptr == LAST_IDX) ? '0 : (wptr + PW'(1));
        wptr_dec   = (wptr == '0) ? LAST_IDX : (wptr - PW'(1));
        top_entry  = stack[wptr_dec];
        push_en    = reset && !stall && !ret && call;
    end

    // Stack storage: written only on an accepted call, contents need no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[wptr] <= pc_inc;
        end
    end

    // PC, occupancy, pointer and sticky error flags with ret > call > branch priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RST_PC;
            depth   <= '0;
            wptr    <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (depth != '0) begin
                    pc    <= top_entry;
                    depth <= depth - DW'(1);
                    wptr  <= wptr_dec;
                end else begin
                    pc      <= pc_inc;
                    unf_err <= 1'b1;
                end
            end else if (call) begin
                pc   <= eff_target;
                wptr <= wptr_inc;
                if (depth == DEPTH_DW) begin
                    ovf_err <= 1'b1;
                end else begin
                    depth <= depth + DW'(1);
                end
            end else if (branch) begin
                pc <= eff_target;
            end else begin
                pc <= pc_inc;
            end
        end
    end

    assign full  = (depth == DEPTH_DW);
    assign empty = (depth == '0);

endmodule
